// File: rtl/gf8_mac_reduce.sv
// gf8_mac_reduce
//   Pipelined GF(2^8) multiply-accumulate stage. Each accepted operand pair
//   (a, b) is multiplied carry-lessly into a 15-bit product, reduced modulo
//   POLY and XOR-accumulated into a running frame sum. A frame closes on
//   in_last, or when it reaches MAX_TERMS terms. In the second case err_ovf
//   latches. Each closed frame emits one 8-bit result with its term count.
//
//   Pipeline: S1 (operand register) -> S2 (product + reduction) -> ACC/output.
//   A single global stall (result held, consumer not ready) freezes every
//   stage, so no beat is ever dropped or duplicated.
//
// Ports
//   clk        in   1   clock, rising edge
//   rst_n      in   1   asynchronous active-low reset
//   in_valid   in   1   operand beat valid
//   in_ready   out  1   stage can accept a beat (low while stalled or in reset)
//   in_a       in   8   operand a, bit0 = x^0
//   in_b       in   8   operand b
//   in_last    in   1   beat is the last term of its frame
//   out_valid  out  1   frame result valid
//   out_ready  in   1   consumer accepts the result
//   out_sum    out  8   XOR-sum of the reduced products of the frame
//   out_count  out  CW  number of terms in the frame
//   err_ovf    out  1   sticky: some frame was force-closed at MAX_TERMS
module gf8_mac_reduce #(
  parameter logic [8:0] POLY      = 9'h11B,
  parameter int         MAX_TERMS = 16,
  localparam int        CW        = $clog2(MAX_TERMS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [7:0]    in_a,
  input  logic [7:0]    in_b,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_sum,
  output logic [CW-1:0] out_count,
  output logic          err_ovf
);

  // Carry-less multiply, then fold bits 14..8 back down with POLY.
  // Folding from the top bit down means a fold never sets a bit that
  // has already been folded.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'(POLY) << (k - 8));
    return p[7:0];
  endfunction

  logic          stall;

  logic          s1_v, s1_last;
  logic [7:0]    s1_a, s1_b;

  logic          s2_v, s2_last;
  logic [7:0]    s2_r;

  logic [7:0]    acc;
  logic [CW-1:0] cnt;

  logic [7:0]    nacc;
  logic [CW-1:0] ncnt;
  logic          hit_max;
  logic          close;

  assign stall    = out_valid & ~out_ready;
  assign in_ready = rst_n & ~stall;

  // NOTE: every always_comb output gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    nacc    = acc ^ s2_r;
    ncnt    = cnt + 1'b1;
    hit_max = 1'b0;
    close   = 1'b0;
    if (s2_v) begin
      hit_max = (ncnt == CW'(MAX_TERMS));
      close   = s2_last | hit_max;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // stage reads the previous-cycle value of the stage before it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are cleared along with the valids so that
      // out_sum/out_count read 0 straight out of reset. These are flops,
      // not RAM, so the reset costs nothing structural.
      s1_v      <= 1'b0;
      s1_last   <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s2_v      <= 1'b0;
      s2_last   <= 1'b0;
      s2_r      <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_count <= '0;
      err_ovf   <= 1'b0;
    end else if (!stall) begin
      // S1: in_ready equals ~stall here, so acceptance is just in_valid.
      s1_v <= in_valid;
      if (in_valid) begin
        s1_a    <= in_a;
        s1_b    <= in_b;
        s1_last <= in_last;
      end

      // S2: reduced product.
      s2_v <= s1_v;
      if (s1_v) begin
        s2_r    <= gf_mul(s1_a, s1_b);
        s2_last <= s1_last;
      end

      // ACC: fold the term in, or close the frame.
      if (s2_v) begin
        if (close) begin
          out_sum   <= nacc;
          out_count <= ncnt;
          acc       <= '0;
          cnt       <= '0;
          if (hit_max && !s2_last) err_ovf <= 1'b1;
        end else begin
          acc <= nacc;
          cnt <= ncnt;
        end
      end

      // Without a stall, a held result is always being taken this edge.
      // A close on the same edge replaces it back-to-back.
      if (close)
        out_valid <= 1'b1;
      else if (out_valid)
        out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gf8_mac_reduce.sv
// tb_gf8_mac_reduce
//   Scoreboard bench for gf8_mac_reduce. Stimulus pushes the expected frame
//   result when it issues a closing beat. A negedge monitor pops and compares
//   on every output transfer. It also checks that held results stay stable.
module tb_gf8_mac_reduce;

  localparam int MAX_TERMS = 16;
  localparam int CW        = $clog2(MAX_TERMS + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_a;
  logic [7:0]    in_b;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [7:0]    out_sum;
  logic [CW-1:0] out_count;
  logic          err_ovf;

  gf8_mac_reduce #(.POLY(9'h11B), .MAX_TERMS(MAX_TERMS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count),
    .err_ovf   (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]    sum;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] sum, input int cnt);
    exp_t e;
    e.sum = sum;
    e.cnt = CW'(cnt);
    q.push_back(e);
  endtask

  // Reference multiply via shift-and-xtime (independent of the DUT's
  // full-product-then-reduce form).
  function automatic logic [7:0] ref_mul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    logic       hi;
    a = a_in; b = b_in; p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      hi = a[7];
      a  = a << 1;
      if (hi) a = a ^ 8'h1B;
      b  = b >> 1;
    end
    return p;
  endfunction

  // Frame model for the random phase.
  logic [7:0] m_acc;
  int         m_cnt;
  logic       m_ovf;

  task automatic model_beat(input logic [7:0] a, input logic [7:0] b, input logic last);
    m_acc = m_acc ^ ref_mul(a, b);
    m_cnt++;
    if (last || m_cnt == MAX_TERMS) begin
      push(m_acc, m_cnt);
      if (!last) m_ovf = 1'b1;
      m_acc = '0;
      m_cnt = 0;
    end
  endtask

  // Drive one beat and hold it until accepted (bounded).
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic last);
    bit ok;
    ok       = 1'b0;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    in_valid = 1'b1;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
    end
    if (!ok) check("send_timeout", 32'(ok), 32'd1);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    repeat (3) @(posedge clk);
    #1;
    check(name, 32'(q.size()), 32'd0);
  endtask

  // Monitor: compares each transfer with the scoreboard head and checks
  // that a stalled result does not change.
  logic          prev_stall = 1'b0;
  logic [7:0]    prev_sum;
  logic [CW-1:0] prev_cnt;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_sum", 32'(out_sum), 32'(prev_sum));
        check("hold_count", 32'(out_count), 32'(prev_cnt));
      end
      if (out_valid && out_ready) begin
        check("result_expected", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_t e;
          e = q.pop_front();
          check("out_sum", 32'(out_sum), 32'(e.sum));
          check("out_count", 32'(out_count), 32'(e.cnt));
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_sum   = out_sum;
      prev_cnt   = out_count;
    end
  end

  bit rand_ready_on = 1'b0;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    m_acc     = '0;
    m_cnt     = 0;
    m_ovf     = 1'b0;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_count", 32'(out_count), 32'd0);
    check("rst_err_ovf", 32'(err_ovf), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // T1: single term, three-edge latency.
    push(8'hC1, 1);
    send(8'h57, 8'h83, 1'b1);
    check("t1_not_yet", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_lat_e1", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("t1_lat_e2", 32'(out_valid), 32'd1);
    drain("t1_drain");

    // T2: two-term frame.
    push(8'h3F, 2);
    send(8'h57, 8'h83, 1'b0);
    send(8'h57, 8'h13, 1'b1);
    drain("t2_drain");

    // T3: reduction corners, back-to-back single-term frames.
    push(8'h1B, 1); send(8'h02, 8'h80, 1'b1);
    push(8'h00, 1); send(8'h01, 8'h00, 1'b1);
    push(8'hFF, 1); send(8'h01, 8'hFF, 1'b1);
    push(8'hA5, 1); send(8'h01, 8'hA5, 1'b1);
    push(8'h13, 1); send(8'hFF, 8'hFF, 1'b1);
    drain("t3_drain");

    // T4: backpressure across three queued frames.
    fork
      begin
        push(8'hC1, 1); send(8'h57, 8'h83, 1'b1);
        push(8'hFE, 1); send(8'h57, 8'h13, 1'b1);
        push(8'h1B, 1); send(8'h02, 8'h80, 1'b1);
      end
      begin
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_out_valid_held", 32'(out_valid), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain("t4_drain");
    check("t4_no_ovf", 32'(err_ovf), 32'd0);

    // T5: forced close after MAX_TERMS, remaining beat forms a new frame.
    push(8'h00, 16);
    push(8'h01, 1);
    for (int i = 0; i < 17; i++) send(8'h01, 8'h01, i == 16);
    drain("t5_drain");
    check("t5_err_ovf", 32'(err_ovf), 32'd1);

    // T6: asynchronous reset mid-frame.
    send(8'h57, 8'h83, 1'b0);
    send(8'h57, 8'h13, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_out_valid", 32'(out_valid), 32'd0);
    check("t6_in_ready", 32'(in_ready), 32'd0);
    check("t6_out_sum", 32'(out_sum), 32'd0);
    check("t6_out_count", 32'(out_count), 32'd0);
    check("t6_err_ovf", 32'(err_ovf), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    push(8'hFE, 1);
    send(8'h57, 8'h13, 1'b1);
    drain("t6_drain");

    // T7: random valid/ready/last against the reference model.
    rand_ready_on = 1'b1;
    fork
      while (rand_ready_on) begin
        @(posedge clk);
        #1;
        if (rand_ready_on) out_ready = ($urandom_range(0, 3) != 0);
      end
      begin
        for (int i = 0; i < 10000; i++) begin
          logic [7:0] a, b;
          logic       last;
          a    = 8'($urandom);
          b    = 8'($urandom);
          last = ($urandom_range(0, 9) == 0) || (i == 9999);
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          model_beat(a, b, last);
          send(a, b, last);
        end
        rand_ready_on = 1'b0;
      end
    join
    out_ready = 1'b1;
    drain("t7_drain");
    check("t7_err_ovf", 32'(err_ovf), 32'(m_ovf));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
